adder_scheduler: RTL and testbench

Shares one `thirtyTwoBitAdder` datapath between two requesters. Each requester selects a lane mode per operation: 1×32, 2×16, 4×8, or a two-beat 64-bit add with carry chained across beats. The block drives the adder's `Split16`/`Split32` controls, arbitrates round-robin, and holds one registered result behind a valid/ready handshake. It sits between the operand sources and the result consumer in the arithmetic unit.

---
 rtl/adder_scheduler_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/thirtyTwoBitAdder.sv | 26 ++
 rtl/adder_scheduler.sv | 131 +++++++++++++
 tb/tb_adder_scheduler.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/adder_scheduler_pkg.sv
// Shared types and the lane-split decode for the adder scheduler.
// Split controls are returned as {split32, split16}.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    M32   = 2'd0,
    M16x2 = 2'd1,
    M8x4  = 2'd2,
    M64   = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // A 64-bit op runs as an unsplit 32-bit add on both beats.
  function automatic logic [1:0] mode_to_split(mode_t mode);
    logic [1:0] split;
    split = 2'b00;
    case (mode)
      M32:     split = 2'b00;
      M16x2:   split = 2'b10;
      M8x4:    split = 2'b11;
      M64:     split = 2'b00;
      default: split = 2'b00;
    endcase
    return split;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. While lock is high only lock_id can be granted;
// advance moves the priority pointer past the current winner.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:1] valid,
  input  logic       lock,
  input  logic       lock_id,
  input  logic       advance,
  output logic       grant_valid,
  output logic       grant_id
);

  logic prio;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prio <= 1'b0;
    else if (advance)
      prio <= ~grant_id;
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = prio;
    if (lock) begin
      grant_id    = lock_id;
      grant_valid = valid[lock_id];
    end else if (valid[0] && valid[1]) begin
      grant_id    = prio;
      grant_valid = 1'b1;
    end else if (valid[0]) begin
      grant_id    = 1'b0;
      grant_valid = 1'b1;
    end else if (valid[1]) begin
      grant_id    = 1'b1;
      grant_valid = 1'b1;
    end
  end

endmodule

// File: rtl/thirtyTwoBitAdder.sv
// Ripple-carry 32-bit adder; index 0 is least significant.
// Split32 cuts the carry into bit 16, Split16 cuts the carries into bits 8 and 24.
module thirtyTwoBitAdder (
  input  logic [0:31] A,
  input  logic [0:31] B,
  input  logic        Ci,
  input  logic        Split16,
  input  logic        Split32,
  output logic [0:31] S,
  output logic        Co
);

  always_comb begin
    logic carry;
    S     = '0;
    carry = Ci;
    for (int i = 0; i < 32; i++) begin
      if ((i == 16 && Split32) || ((i == 8 || i == 24) && Split16))
        carry = 1'b0;
      S[i]  = A[i] ^ B[i] ^ carry;
      carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Co = carry;
  end

endmodule

// File: rtl/adder_scheduler.sv
// Shares one thirtyTwoBitAdder between two requesters with lane modes and a
// two-beat 64-bit add, holding a single registered result behind valid/ready.
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [0:NREQ-1]            req_valid,
  output logic [0:NREQ-1]            req_ready,
  input  logic [0:NREQ-1][1:0]       req_mode,
  input  logic [0:NREQ-1][0:31]      req_A,
  input  logic [0:NREQ-1][0:31]      req_B,
  input  logic [0:NREQ-1]            req_Ci,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [0:31]                res_S,
  output logic                       res_Co,
  output logic                       res_id,
  output logic                       res_last
);

  state_t      state, state_next;
  logic        lock_id;
  logic        carry_q;
  logic        grant_valid;
  logic        grant_id;
  logic        accept;
  logic        beat_last;
  logic        adder_ci;
  logic [1:0]  split;
  logic [0:31] sum;
  logic        co;
  mode_t       gmode;

  assign gmode  = mode_t'(req_mode[grant_id]);
  assign accept = grant_valid && (!res_valid || res_ready);

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .valid       (req_valid),
    .lock        (state == LOCK),
    .lock_id     (lock_id),
    .advance     (accept && beat_last),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  thirtyTwoBitAdder u_adder (
    .A       (req_A[grant_id]),
    .B       (req_B[grant_id]),
    .Ci      (adder_ci),
    .Split16 (split[0]),
    .Split32 (split[1]),
    .S       (sum),
    .Co      (co)
  );

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[grant_id] = 1'b1;
  end

  // The second 64-bit beat ignores the requester's mode and carry-in.
  always_comb begin
    state_next = state;
    split      = 2'b00;
    adder_ci   = req_Ci[grant_id];
    beat_last  = 1'b1;
    case (state)
      IDLE: begin
        split = mode_to_split(gmode);
        if (gmode == M64) begin
          beat_last = 1'b0;
          if (accept)
            state_next = LOCK;
        end
      end
      LOCK: begin
        adder_ci = carry_q;
        if (accept)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      lock_id <= 1'b0;
    end else if (accept) begin
      if (state == IDLE && gmode == M64) begin
        carry_q <= co;
        lock_id <= grant_id;
      end else if (state == LOCK) begin
        carry_q <= 1'b0;
      end
    end
  end

  // A drain and a new accept in the same cycle simply reloads the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_S     <= '0;
      res_Co    <= 1'b0;
      res_id    <= 1'b0;
      res_last  <= 1'b1;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_S     <= sum;
      res_Co    <= co;
      res_id    <= grant_id;
      res_last  <= beat_last;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_scheduler.sv
// Randomized and directed bench for adder_scheduler against a lane-arithmetic
// reference model of arbitration, 64-bit chaining and the result register.
module tb_adder_scheduler;

  logic             clk = 1'b0;
  logic             rst;
  logic [0:1]       reqValid;
  logic [0:1]       reqReady;
  logic [0:1][1:0]  reqMode;
  logic [0:1][0:31] reqA;
  logic [0:1][0:31] reqB;
  logic [0:1]       reqCi;
  logic             resValid;
  logic             resReady;
  logic [0:31]      resS;
  logic             resCo;
  logic             resId;
  logic             resLast;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] opA [2];
  logic [31:0] opB [2];

  logic        mValid;
  logic [31:0] mS;
  logic        mCo, mId, mLast;
  logic        mPrio, mLocked, mLockId, mCarry;

  always #5 clk = ~clk;

  adder_scheduler #(.NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_mode  (reqMode),
    .req_A     (reqA),
    .req_B     (reqB),
    .req_Ci    (reqCi),
    .res_valid (resValid),
    .res_ready (resReady),
    .res_S     (resS),
    .res_Co    (resCo),
    .res_id    (resId),
    .res_last  (resLast)
  );

  // Ports number bits with index 0 as the least significant bit.
  function automatic logic [0:31] toPort(logic [31:0] v);
    logic [0:31] r;
    for (int i = 0; i < 32; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [31:0] fromPort(logic [0:31] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[i];
    return r;
  endfunction

  // Independent lane adds; carry-in enters lane 0, Co is the top lane's carry.
  function automatic logic [32:0] refAdd(logic [31:0] a, logic [31:0] b, logic ci, int lanes);
    int          w;
    longint      mask, la, lb, s;
    logic [31:0] sum;
    logic        co;
    w    = 32 / lanes;
    mask = (longint'(1) << w) - 1;
    la   = longint'(a);
    lb   = longint'(b);
    sum  = '0;
    co   = 1'b0;
    for (int k = 0; k < lanes; k++) begin
      s   = ((la >> (k * w)) & mask) + ((lb >> (k * w)) & mask) + ((k == 0) ? longint'(ci) : 0);
      sum = sum | (32'(s & mask) << (k * w));
      if (k == lanes - 1) co = ((s >> w) & 1) != 0;
    end
    return {co, sum};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkResult();
    checkOutput("res_valid", 64'(resValid), 64'(mValid));
    checkOutput("res_S", 64'(fromPort(resS)), 64'(mS));
    checkOutput("res_Co", 64'(resCo), 64'(mCo));
    checkOutput("res_id", 64'(resId), 64'(mId));
    checkOutput("res_last", 64'(resLast), 64'(mLast));
  endtask

  task automatic modelReset();
    mValid = 1'b0; mS = '0; mCo = 1'b0; mId = 1'b0; mLast = 1'b1;
    mPrio = 1'b0; mLocked = 1'b0; mLockId = 1'b0; mCarry = 1'b0;
  endtask

  // Predicts which requester is accepted this cycle and the resulting register.
  task automatic modelCycle();
    logic [0:1]  expReady;
    logic        hasCand, cand, accept;
    logic [32:0] r;
    int          lanes;
    expReady = 2'b00;
    hasCand  = 1'b0;
    cand     = 1'b0;
    if (mLocked) begin
      if (reqValid[mLockId]) begin hasCand = 1'b1; cand = mLockId; end
    end else if (reqValid[0] && reqValid[1]) begin
      hasCand = 1'b1; cand = mPrio;
    end else if (reqValid[0]) begin
      hasCand = 1'b1; cand = 1'b0;
    end else if (reqValid[1]) begin
      hasCand = 1'b1; cand = 1'b1;
    end
    accept = hasCand && (!mValid || resReady);
    if (accept) expReady[cand] = 1'b1;
    checkOutput("req_ready", 64'(reqReady), 64'(expReady));
    if (accept) begin
      if (mLocked) begin
        r = refAdd(opA[cand], opB[cand], mCarry, 1);
        mLast = 1'b1; mLocked = 1'b0; mCarry = 1'b0; mPrio = ~cand;
      end else if (reqMode[cand] == 2'd3) begin
        r = refAdd(opA[cand], opB[cand], reqCi[cand], 1);
        mLast = 1'b0; mLocked = 1'b1; mLockId = cand; mCarry = r[32];
      end else begin
        lanes = 1 << int'(reqMode[cand]);
        r = refAdd(opA[cand], opB[cand], reqCi[cand], lanes);
        mLast = 1'b1; mPrio = ~cand;
      end
      mS = r[31:0]; mCo = r[32]; mId = cand; mValid = 1'b1;
    end else if (resReady) begin
      mValid = 1'b0;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    reqValid = 2'b00;
    modelReset();
    #1;
    checkResult();
    checkOutput("reset_ready", 64'(reqReady), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [0:1] v, input logic [1:0] m0, input logic [1:0] m1,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic c0, input logic c1, input logic rr);
    reqValid = v;
    reqMode[0] = m0; reqMode[1] = m1;
    opA[0] = a0; opB[0] = b0; opA[1] = a1; opB[1] = b1;
    reqA[0] = toPort(a0); reqB[0] = toPort(b0);
    reqA[1] = toPort(a1); reqB[1] = toPort(b1);
    reqCi[0] = c0; reqCi[1] = c1;
    resReady = rr;
    @(negedge clk);
    modelCycle();
    @(posedge clk);
    #1;
    checkResult();
  endtask

  initial begin
    rst = 1'b1;
    reqValid = '0; reqMode = '0; reqA = '0; reqB = '0; reqCi = '0; resReady = 1'b1;
    opA[0] = '0; opA[1] = '0; opB[0] = '0; opB[1] = '0;
    doReset();

    applyStimulus(2'b10, 2'd0, 2'd0, 32'hFFFFFFFF, 32'd1, 0, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("tp_wrap_S", 64'(fromPort(resS)), 64'd0);
    checkOutput("tp_wrap_Co", 64'(resCo), 64'd1);

    applyStimulus(2'b01, 2'd0, 2'd2, 0, 0, 32'h01FF01FF, 32'h01010101, 1'b0, 1'b0, 1'b1);
    checkOutput("tp_8x4_S", 64'(fromPort(resS)), 64'h02000200);
    applyStimulus(2'b01, 2'd0, 2'd1, 0, 0, 32'h01FF01FF, 32'h01010101, 1'b0, 1'b0, 1'b1);
    checkOutput("tp_16x2_S", 64'(fromPort(resS)), 64'h03000300);

    applyStimulus(2'b11, 2'd3, 2'd0, 32'hFFFFFFFF, 32'd1, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
    checkOutput("tp_b1_S", 64'(fromPort(resS)), 64'd0);
    checkOutput("tp_b1_last", 64'(resLast), 64'd0);
    applyStimulus(2'b11, 2'd0, 2'd0, 32'd0, 32'd0, 32'd5, 32'd6, 1'b1, 1'b0, 1'b1);
    checkOutput("tp_b2_S", 64'(fromPort(resS)), 64'd1);
    checkOutput("tp_b2_last", 64'(resLast), 64'd1);
    applyStimulus(2'b11, 2'd0, 2'd0, 32'd1, 32'd2, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
    checkOutput("tp_after_lock_id", 64'(resId), 64'd1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 2'd0, 2'd0, 32'(i), 32'd10, 32'(i + 100), 32'd20, 1'b0, 1'b1, 1'b1);
      checkOutput("tp_alternate", 64'(resId), 64'(i % 2));
    end
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b11, 2'd0, 2'd0, 32'd7, 32'd7, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'd0, 2'd0, 32'd7, 32'd7, 32'd9, 32'd9, 1'b0, 1'b0, 1'b1);

    applyStimulus(2'b10, 2'd3, 2'd0, 32'hFFFFFFFF, 32'd1, 0, 0, 1'b0, 1'b0, 1'b1);
    doReset();
    applyStimulus(2'b10, 2'd3, 2'd0, 32'd0, 32'd0, 0, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("tp_rst_b1_S", 64'(fromPort(resS)), 64'd0);
    checkOutput("tp_rst_b1_last", 64'(resLast), 64'd0);
    applyStimulus(2'b10, 2'd3, 2'd0, 32'd0, 32'd0, 0, 0, 1'b1, 1'b0, 1'b1);
    checkOutput("tp_rst_b2_S", 64'(fromPort(resS)), 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a0, b0, a1, b1;
      a0 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? 32'h01010101 : $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? 32'h00010001 : $urandom;
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    a0, b0, a1, b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
